// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor for one HLS instance: merges AXI-Stream and sub-instance
// block indicators and flags a block only once the condition has persisted.
module hls_deadlock_persist_monitor #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_SUB  = 1,
  parameter int THRESH   = 1,
  parameter int STICKY   = 0,
  parameter int EVT_W    = 16,
  localparam int SUB_W   = (NUM_SUB > 0) ? NUM_SUB : 1,
  localparam int CAUSE_W = NUM_AXIS + NUM_SUB
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [SUB_W-1:0]   inst_idle_sigs,
  input  logic [SUB_W-1:0]   inst_block_sigs,
  input  logic               clear,
  output logic               block,
  output logic [CAUSE_W-1:0] block_cause,
  output logic [EVT_W-1:0]   event_count
);

  localparam int CW = $clog2(THRESH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      runCnt_q;
  logic               block_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [EVT_W-1:0]   count_q;

  logic               axisTerm;
  logic               subTerm;
  logic               raw;
  logic [CAUSE_W-1:0] causeSnap_d;
  logic [EVT_W-1:0]   countInc_d;

  assign axisTerm = |axis_block_sigs;

  // Sub term: every sub-instance is stalled or idle, and at least one is stalled.
  generate
    if (NUM_SUB > 0) begin : g_sub
      assign subTerm     = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
      assign causeSnap_d = {inst_block_sigs, axis_block_sigs};
    end else begin : g_nosub
      logic unusedSub;
      assign unusedSub   = ^{inst_idle_sigs, inst_block_sigs};
      assign subTerm     = 1'b0;
      assign causeSnap_d = axis_block_sigs;
    end
  endgenerate

  assign raw        = axisTerm | subTerm;
  assign countInc_d = (&count_q) ? count_q : count_q + EVT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      runCnt_q <= '0;
      block_q  <= 1'b0;
      cause_q  <= '0;
      count_q  <= '0;
    end else if (clear) begin
      state_q  <= IDLE;
      runCnt_q <= '0;
      block_q  <= 1'b0;
      cause_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (raw && (THRESH == 1)) begin
            state_q  <= BLOCKED;
            runCnt_q <= CW'(THRESH);
            block_q  <= 1'b1;
            cause_q  <= causeSnap_d;
            count_q  <= countInc_d;
          end else if (raw) begin
            state_q  <= PENDING;
            runCnt_q <= CW'(1);
          end else begin
            runCnt_q <= '0;
          end
        end
        PENDING: begin
          if (!raw) begin
            state_q  <= IDLE;
            runCnt_q <= '0;
          end else if (runCnt_q == CW'(THRESH - 1)) begin
            state_q  <= BLOCKED;
            runCnt_q <= CW'(THRESH);
            block_q  <= 1'b1;
            cause_q  <= causeSnap_d;
            count_q  <= countInc_d;
          end else begin
            runCnt_q <= runCnt_q + CW'(1);
          end
        end
        BLOCKED: begin
          // Sticky mode ignores raw entirely; only clear or reset leave BLOCKED.
          if ((STICKY == 0) && !raw) begin
            state_q  <= IDLE;
            runCnt_q <= '0;
            block_q  <= 1'b0;
            cause_q  <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          runCnt_q <= '0;
          block_q  <= 1'b0;
          cause_q  <= '0;
        end
      endcase
    end
  end

  assign block       = block_q;
  assign block_cause = cause_q;
  assign event_count = count_q;

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Scoreboard bench for hls_deadlock_persist_monitor: three parameterisations
// driven by directed per-cycle vectors with hand-computed expected outputs.
module tb_hls_deadlock_persist_monitor;

  typedef struct {
    int         idx;
    int         dut;
    logic       rst;
    logic       clr;
    logic [1:0] axis;
    logic [1:0] idle;
    logic [1:0] blk;
    logic       expBlock;
    logic [3:0] expCause;
    logic [15:0] expCount;
  } vec_t;

  logic clock;
  logic reset;

  logic [1:0] axisA, axisB, axisC;
  logic [0:0] idleA, blkA, idleC, blkC;
  logic [1:0] idleB, blkB;
  logic       clearA, clearB, clearC;
  logic       blockA, blockB, blockC;
  logic [2:0] causeA, causeC;
  logic [3:0] causeB;
  logic [15:0] countA, countB;
  logic [1:0] countC;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];
  vec_t sb[$];

  hls_deadlock_persist_monitor #(.NUM_AXIS(2), .NUM_SUB(1), .THRESH(1), .STICKY(0), .EVT_W(16)) dutA (
    .clock(clock), .reset(reset), .axis_block_sigs(axisA), .inst_idle_sigs(idleA),
    .inst_block_sigs(blkA), .clear(clearA), .block(blockA), .block_cause(causeA),
    .event_count(countA));

  hls_deadlock_persist_monitor #(.NUM_AXIS(2), .NUM_SUB(2), .THRESH(4), .STICKY(0), .EVT_W(16)) dutB (
    .clock(clock), .reset(reset), .axis_block_sigs(axisB), .inst_idle_sigs(idleB),
    .inst_block_sigs(blkB), .clear(clearB), .block(blockB), .block_cause(causeB),
    .event_count(countB));

  hls_deadlock_persist_monitor #(.NUM_AXIS(2), .NUM_SUB(1), .THRESH(2), .STICKY(1), .EVT_W(2)) dutC (
    .clock(clock), .reset(reset), .axis_block_sigs(axisC), .inst_idle_sigs(idleC),
    .inst_block_sigs(blkC), .clear(clearC), .block(blockC), .block_cause(causeC),
    .event_count(countC));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic addVec(input int dut, input logic rst, input logic clr,
                        input logic [1:0] axis, input logic [1:0] idle, input logic [1:0] blk,
                        input logic eb, input logic [3:0] ec, input logic [15:0] en);
    vec_t v;
    v.idx = vecs.size();
    v.dut = dut; v.rst = rst; v.clr = clr;
    v.axis = axis; v.idle = idle; v.blk = blk;
    v.expBlock = eb; v.expCause = ec; v.expCount = en;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset  = v.rst;
    axisA  = (v.dut == 0) ? v.axis : 2'b00;
    idleA  = (v.dut == 0) ? v.idle[0:0] : 1'b0;
    blkA   = (v.dut == 0) ? v.blk[0:0] : 1'b0;
    clearA = (v.dut == 0) ? v.clr : 1'b0;
    axisB  = (v.dut == 1) ? v.axis : 2'b00;
    idleB  = (v.dut == 1) ? v.idle : 2'b00;
    blkB   = (v.dut == 1) ? v.blk : 2'b00;
    clearB = (v.dut == 1) ? v.clr : 1'b0;
    axisC  = (v.dut == 2) ? v.axis : 2'b00;
    idleC  = (v.dut == 2) ? v.idle[0:0] : 1'b0;
    blkC   = (v.dut == 2) ? v.blk[0:0] : 1'b0;
    clearC = (v.dut == 2) ? v.clr : 1'b0;
    sb.push_back(v);
  endtask

  task automatic checkOne(input string name, input vec_t v, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d vec%0d: got 0x%0h expected 0x%0h", name, v.dut, v.idx, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    logic        b;
    logic [15:0] c;
    logic [15:0] n;
    case (v.dut)
      0:       begin b = blockA; c = {13'd0, causeA}; n = countA; end
      1:       begin b = blockB; c = {12'd0, causeB}; n = countB; end
      default: begin b = blockC; c = {13'd0, causeC}; n = {14'd0, countC}; end
    endcase
    checkOne("block", v, {15'd0, b}, {15'd0, v.expBlock});
    checkOne("block_cause", v, c, {12'd0, v.expCause});
    checkOne("event_count", v, n, v.expCount);
  endtask

  // Monitor: every clock the DUT presents a new registered result.
  initial begin
    vec_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1;
    axisA = '0; idleA = '0; blkA = '0; clearA = 1'b0;
    axisB = '0; idleB = '0; blkB = '0; clearB = 1'b0;
    axisC = '0; idleC = '0; blkC = '0; clearC = 1'b0;

    // Reset state of every instance.
    addVec(0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0);
    addVec(1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0);
    addVec(2, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0);

    // A: THRESH=1, STICKY=0 -> one-cycle registered OR.
    for (int i = 0; i < 3; i++) addVec(0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h1, 1);
    addVec(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 1);
    addVec(0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 4'h2, 2);
    addVec(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 2);
    addVec(0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 4'h4, 3);
    addVec(0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 4'h0, 3);
    addVec(0, 0, 0, 2'b11, 2'b01, 2'b01, 1, 4'h7, 4);
    addVec(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 4);
    addVec(0, 0, 1, 2'b01, 2'b00, 2'b00, 0, 4'h0, 4);
    addVec(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 4);

    // B: THRESH=4, interrupted burst then full burst.
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 0);
    addVec(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 0);
    addVec(1, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h1, 1);
    addVec(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 1);
    // B: sub term, one blocked plus one idle.
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'h0, 1);
    addVec(1, 0, 0, 2'b00, 2'b10, 2'b01, 1, 4'h4, 2);
    addVec(1, 0, 0, 2'b00, 2'b00, 2'b01, 0, 4'h0, 2);
    for (int i = 0; i < 5; i++) addVec(1, 0, 0, 2'b00, 2'b11, 2'b00, 0, 4'h0, 2);
    // B: clear together with raw while pending restarts the count.
    addVec(1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 2);
    addVec(1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 2);
    addVec(1, 0, 1, 2'b01, 2'b00, 2'b00, 0, 4'h0, 2);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 2);
    addVec(1, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h1, 3);
    addVec(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 3);

    // C: THRESH=2, STICKY=1, EVT_W=2.
    addVec(2, 0, 0, 2'b10, 2'b00, 2'b00, 0, 4'h0, 0);
    addVec(2, 0, 0, 2'b10, 2'b00, 2'b00, 1, 4'h2, 1);
    for (int i = 0; i < 10; i++) addVec(2, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'h2, 1);
    addVec(2, 0, 1, 2'b00, 2'b00, 2'b00, 0, 4'h0, 1);
    addVec(2, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 1);
    // C: further episodes drive the 2-bit counter into saturation.
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 1);
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h1, 2);
    addVec(2, 0, 1, 2'b00, 2'b00, 2'b00, 0, 4'h0, 2);
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 2);
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h1, 3);
    addVec(2, 0, 1, 2'b00, 2'b00, 2'b00, 0, 4'h0, 3);
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 3);
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h1, 3);
    addVec(2, 0, 1, 2'b00, 2'b00, 2'b00, 0, 4'h0, 3);
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 3);
    addVec(2, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'h1, 3);
    // C: reset while blocked clears everything.
    addVec(2, 1, 0, 2'b01, 2'b00, 2'b00, 0, 4'h0, 0);
    addVec(2, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'h0, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
    end

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(negedge clock);
      wait_cycles++;
    end
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_persist_monitor.md
# hls_deadlock_persist_monitor

Parametrised deadlock monitor for one HLS instance in the gaussian_nb hierarchy. It combines any number of AXI-Stream block indicators and sub-instance idle/block indicators into a raw block condition. It asserts `block` only after that condition has persisted for a programmable number of cycles. It optionally latches the result until software clears it, and it reports which sources caused the block and how often blocking has occurred.

## Interface
Parameters:
- NUM_AXIS, 2, number of AXI-Stream block inputs (≥1)
- NUM_SUB, 1, number of sub-instance idle/block pairs (≥0; 0 disables sub term)
- THRESH, 1, consecutive raw-block cycles required before `block` asserts (≥1)
- STICKY, 0, 1 = `block` holds until `clear`; 0 = `block` follows raw condition
- EVT_W, 16, width of event counter

Ports:
- clock  in  1  clock
- reset  in  1  reset; synchronous, active-high
- axis_block_sigs  in  NUM_AXIS  per-stream blocked indicator
- inst_idle_sigs  in  max(NUM_SUB,1)  per-sub-instance idle
- inst_block_sigs  in  max(NUM_SUB,1)  per-sub-instance blocked
- clear  in  1  single-cycle clear of latched state (meaningful when STICKY=1; also accepted when STICKY=0)
- block  out  1  deadlock detected
- block_cause  out  NUM_AXIS+NUM_SUB  snapshot {inst_block_sigs, axis_block_sigs} at block entry
- event_count  out  EVT_W  number of block entries, saturating

## Operation
- axis_term = OR of axis_block_sigs.
- sub_term is 0 when NUM_SUB=0. Otherwise sub_term = AND over i of (inst_block_sigs[i] | inst_idle_sigs[i]), AND-ed with (OR of inst_block_sigs). All subs are stalled or idle, and at least one is blocked.
- raw = axis_term | sub_term. Purely combinational; not registered.
- FSM states: IDLE, PENDING, BLOCKED. Run counter `run_cnt`, width clog2(THRESH+1), saturates at THRESH.
- IDLE:
  - raw & THRESH==1 -> BLOCKED.
  - raw & THRESH>1 -> PENDING with run_cnt=1.
  - Otherwise stay, run_cnt=0.
- PENDING:
  - !raw -> IDLE, run_cnt=0.
  - raw & run_cnt==THRESH-1 -> BLOCKED.
  - Otherwise run_cnt+1.
- BLOCKED, STICKY=0: !raw -> IDLE, run_cnt=0, block_cause=0. While raw stays high, remain in BLOCKED with block_cause held.
- BLOCKED, STICKY=1: remain until `clear`; raw is ignored.
- On each transition into BLOCKED:
  - block_cause <= {inst_block_sigs, axis_block_sigs}, sampled that edge.
  - event_count increments, saturating at all-ones.
- `block` = (state==BLOCKED), registered.
- `clear` has priority over every transition except reset. It forces IDLE, run_cnt=0 and block_cause=0. The raw value in the same cycle is discarded, and counting restarts on the next cycle. `clear` never modifies event_count.
- reset: state=IDLE, run_cnt=0, block=0, block_cause=0, event_count=0. Reset mid-PENDING or mid-BLOCKED discards all progress.
- With THRESH=1, STICKY=0, NUM_AXIS=2, NUM_SUB=1, `block` equals a one-cycle-registered OR of the AXIS block inputs; the sub term can additionally contribute.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- If raw is high at edges e0 … e0+THRESH-1, `block` is high after edge e0+THRESH-1. Latency = THRESH cycles from first raw-high cycle.
- A raw drop at any edge before THRESH restarts the count. A later re-assertion needs THRESH fresh cycles.
- STICKY=0: `block` deasserts one cycle after raw falls.
- STICKY=1: `block` deasserts one cycle after `clear` is sampled.
- block_cause and event_count update on the same edge that `block` rises.

## Test plan
- THRESH=1, STICKY=0: axis_block_sigs=2'b01 for 3 cycles -> block high cycles 2–4, block_cause=3'b001, event_count=1, block low cycle 5.
- THRESH=4: raw high 3 cycles, low 1, high 4 -> no block during first burst; block rises after 4th cycle of second burst; event_count=1.
- Sub term, NUM_SUB=2: block={1,0}, idle={0,1} -> block after THRESH cycles. Then idle={0,0} -> raw=0 and block drops (STICKY=0). With block=0, idle=2'b11 -> never blocks.
- STICKY=1, THRESH=2: raw high 2 cycles then low 10 -> block stays high. `clear` pulse -> block low next cycle, block_cause=0, event_count unchanged at 1.
- Simultaneous `clear` and raw high in PENDING -> IDLE, run_cnt=0; block requires THRESH further raw cycles.
- event_count saturation (EVT_W=2): 5 block episodes -> event_count=3. Reset asserted mid-BLOCKED -> all outputs 0 the next cycle.
